// File: rtl/tdc_stim_pkg.sv
// Shared types and default widths for the TDC stimulus generator.
package tdc_stim_pkg;

  localparam int DELAY_W_DEF = 8;
  localparam int WIDTH_W_DEF = 4;
  localparam int REP_W       = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_HOLD,
    S_GAP,
    S_DONE
  } state_e;

endpackage

// File: rtl/tdc_stim_cnt.sv
// Loadable down-counter that sticks at zero instead of wrapping.
module tdc_stim_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  input  logic         dec_i,
  output logic         last_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Final cycle of the current phase.
  assign last_o = (cnt_q == W'(1));

endmodule

// File: rtl/tdc_stim_gen.sv
// Start/stop stimulus generator for a TDC; one run per trig_i rising edge.
// Define TDC_STIM_REPEAT_EN to add rep_i/run_o and back-to-back burst runs.
module tdc_stim_gen
  import tdc_stim_pkg::*;
#(
  parameter int DELAY_W = DELAY_W_DEF,
  parameter int WIDTH_W = WIDTH_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic               trig_i,
  input  logic [DELAY_W-1:0] delay_i,
  input  logic [WIDTH_W-1:0] width_i,
`ifdef TDC_STIM_REPEAT_EN
  input  logic [REP_W-1:0]   rep_i,
  output logic [REP_W-1:0]   run_o,
`endif
  output logic               start_o,
  output logic               stop_o,
  output logic               busy_o,
  output logic               done_o
);

  localparam int CNT_W = (DELAY_W > WIDTH_W) ? DELAY_W : WIDTH_W;

  state_e             state_q, state_d;
  logic               trig_q, trig_d;
  logic               arm_q, arm_d;
  logic [WIDTH_W-1:0] w_q, w_d;
  logic               start_q, start_d, stop_q, stop_d;
  logic               busy_q, busy_d, done_q, done_d;
`ifdef TDC_STIM_REPEAT_EN
  logic [DELAY_W-1:0] d_q, d_d;
  logic [REP_W-1:0]   rep_q, rep_d, run_q, run_d;
`endif

  logic               cnt_load, cnt_dec, cnt_last;
  logic [CNT_W-1:0]   cnt_val;
  logic [DELAY_W-1:0] d_sat;
  logic [WIDTH_W-1:0] w_sat;
  logic               trig_edge;

  assign d_sat = (delay_i == '0) ? DELAY_W'(1) : delay_i;
  assign w_sat = (width_i == '0) ? WIDTH_W'(1) : width_i;
  // arm_q masks the first cycle after reset so a trig_i held high is not an edge.
  assign trig_edge = arm_q && trig_i && !trig_q;

  always_comb begin
    state_d  = state_q;
    trig_d   = trig_i;
    arm_d    = 1'b1;
    w_d      = w_q;
    start_d  = start_q;
    stop_d   = stop_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    cnt_val  = '0;
`ifdef TDC_STIM_REPEAT_EN
    d_d      = d_q;
    rep_d    = rep_q;
    run_d    = run_q;
`endif
    if (!ena) begin
      state_d = S_IDLE;
      start_d = 1'b0;
      stop_d  = 1'b0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (trig_edge) begin
            state_d  = S_START;
            w_d      = w_sat;
            start_d  = 1'b1;
            busy_d   = 1'b1;
            cnt_load = 1'b1;
            cnt_val  = CNT_W'(d_sat);
`ifdef TDC_STIM_REPEAT_EN
            d_d      = d_sat;
            rep_d    = rep_i;
            run_d    = '0;
`endif
          end
        end
        S_START: begin
          if (cnt_last) begin
            state_d  = S_HOLD;
            stop_d   = 1'b1;
            cnt_load = 1'b1;
            cnt_val  = CNT_W'(w_q);
          end else begin
            cnt_dec = 1'b1;
          end
        end
        S_HOLD: begin
          if (cnt_last) begin
            start_d = 1'b0;
            stop_d  = 1'b0;
`ifdef TDC_STIM_REPEAT_EN
            if (run_q != rep_q) begin
              state_d  = S_GAP;
              cnt_load = 1'b1;
              cnt_val  = CNT_W'(w_q);
            end else begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end
`else
            state_d = S_DONE;
            done_d  = 1'b1;
`endif
          end else begin
            cnt_dec = 1'b1;
          end
        end
`ifdef TDC_STIM_REPEAT_EN
        S_GAP: begin
          if (cnt_last) begin
            state_d  = S_START;
            start_d  = 1'b1;
            cnt_load = 1'b1;
            cnt_val  = CNT_W'(d_q);
            run_d    = run_q + REP_W'(1);
          end else begin
            cnt_dec = 1'b1;
          end
        end
`endif
        S_DONE: begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
        default: begin
          state_d = S_IDLE;
          start_d = 1'b0;
          stop_d  = 1'b0;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      trig_q  <= 1'b0;
      arm_q   <= 1'b0;
      w_q     <= '0;
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef TDC_STIM_REPEAT_EN
      d_q     <= '0;
      rep_q   <= '0;
      run_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      trig_q  <= trig_d;
      arm_q   <= arm_d;
      w_q     <= w_d;
      start_q <= start_d;
      stop_q  <= stop_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef TDC_STIM_REPEAT_EN
      d_q     <= d_d;
      rep_q   <= rep_d;
      run_q   <= run_d;
`endif
    end
  end

  tdc_stim_cnt #(.W(CNT_W)) u_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (cnt_load),
    .val_i  (cnt_val),
    .dec_i  (cnt_dec),
    .last_o (cnt_last)
  );

  assign start_o = start_q;
  assign stop_o  = stop_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;
`ifdef TDC_STIM_REPEAT_EN
  assign run_o   = run_q;
`endif

endmodule

// File: tb/tb_tdc_stim_gen.sv
// Self-checking bench for tdc_stim_gen: directed scenarios plus random traffic against a schedule model.
module tb_tdc_stim_gen;

  localparam int INF = 1 << 30;
`ifdef TDC_STIM_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic       trig_i = 1'b0;
  logic [7:0] delay_i = '0;
  logic [3:0] width_i = '0;
  logic [3:0] rep_i = '0;
  logic [3:0] run_w;
  logic       start_o, stop_o, busy_o, done_o;

  int checks = 0;
  int errors = 0;

  tdc_stim_gen #(.DELAY_W(8), .WIDTH_W(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .trig_i  (trig_i),
    .delay_i (delay_i),
    .width_i (width_i),
`ifdef TDC_STIM_REPEAT_EN
    .rep_i   (rep_i),
    .run_o   (run_w),
`endif
    .start_o (start_o),
    .stop_o  (stop_o),
    .busy_o  (busy_o),
    .done_o  (done_o)
  );

`ifndef TDC_STIM_REPEAT_EN
  assign run_w = '0;
`endif

  always #5 clk = ~clk;

  // Reference model: one accepted run described by its trigger cycle and (D, W, reps);
  // outputs at any cycle follow from arithmetic on the offset into that schedule.
  int         cyc = 0;
  int         m_t0 = 0, m_d = 1, m_w = 1, m_rep = 0, m_kill = INF;
  bit         m_valid = 1'b0, armed = 1'b0, prev_trig = 1'b0;
  logic [3:0] m_run_rest = '0;

  function automatic logic [7:0] exp_vec(input int c);
    int total, p, cc, off, ph;
    logic s, t, b, dn;
    logic [3:0] run;
    s = 1'b0; t = 1'b0; b = 1'b0; dn = 1'b0; run = m_run_rest;
    if (m_valid && c > m_t0) begin
      total = (m_rep + 1) * (m_d + m_w) + m_rep * m_w;
      p     = m_d + 2 * m_w;
      cc    = (c >= m_kill) ? m_kill - 1 : c;
      off   = cc - m_t0;
      run   = (off > total) ? 4'(m_rep) : 4'((off - 1) / p);
      if (c < m_kill) begin
        if (off <= total) begin
          ph = (off - 1) % p;
          s  = (ph < m_d + m_w);
          t  = (ph >= m_d) && (ph < m_d + m_w);
          b  = 1'b1;
        end else if (off == total + 1) begin
          b  = 1'b1;
          dn = 1'b1;
        end
      end
    end
    return {s, t, b, dn, run};
  endfunction

  function automatic logic [3:0] exp_run(input int c);
    logic [7:0] v;
    v = exp_vec(c);
    return v[3:0];
  endfunction

  function automatic bit model_idle(input int c);
    int total;
    if (!m_valid) return 1'b1;
    total = (m_rep + 1) * (m_d + m_w) + m_rep * m_w;
    return (c >= m_kill) || (c >= m_t0 + total + 2);
  endfunction

  function automatic logic [7:0] got_vec();
    return {start_o, stop_o, busy_o, done_o, run_w};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid    <= 1'b0;
      m_run_rest <= '0;
      m_kill     <= INF;
      armed      <= 1'b0;
      prev_trig  <= 1'b0;
    end else begin
      cyc       <= cyc + 1;
      armed     <= 1'b1;
      prev_trig <= trig_i;
      if (armed && trig_i && !prev_trig && ena && model_idle(cyc)) begin
        m_run_rest <= exp_run(cyc);
        m_valid    <= 1'b1;
        m_t0       <= cyc;
        m_d        <= (delay_i == 0) ? 1 : int'(delay_i);
        m_w        <= (width_i == 0) ? 1 : int'(width_i);
        m_rep      <= REP_EN ? int'(rep_i) : 0;
        m_kill     <= INF;
        $display("cycle %0d: run accepted delay_i=%0d width_i=%0d rep=%0d",
                 cyc, delay_i, width_i, REP_EN ? int'(rep_i) : 0);
      end else if (!ena && m_valid && cyc < m_kill) begin
        m_kill <= cyc + 1;
      end
    end
  end

  task automatic test_reset;
    rst_n = 1'b0; ena = 1'b0; trig_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (got_vec() !== 8'h00) begin
        errors++;
        $display("FAIL reset_state got=%b expected=%b", got_vec(), 8'h00);
      end
    end
    rst_n = 1'b1; ena = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic;
    int t0, st = -1, sp = -1, fl = -1, dn_at = -1, dn = 0;
    delay_i = 8'd5; width_i = 4'd3; rep_i = 4'd0;
    trig_i = 1'b1; t0 = cyc;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      checks++;
      if (got_vec() !== exp_vec(cyc)) begin
        errors++;
        $display("FAIL basic_cycle cyc=%0d got=%b expected=%b", cyc, got_vec(), exp_vec(cyc));
      end
      if (start_o && st < 0) st = cyc - t0;
      if (stop_o && sp < 0) sp = cyc - t0;
      if (st >= 0 && !start_o && fl < 0) fl = cyc - t0;
      if (done_o) begin dn++; dn_at = cyc - t0; end
      if (k == 1) begin
        trig_i = 1'b0;
        delay_i = 8'($urandom_range(20, 200));
        width_i = 4'($urandom_range(6, 15));
      end
    end
    checks++;
    if (st !== 1 || sp !== 6 || fl !== 9 || dn_at !== 9 || dn !== 1) begin
      errors++;
      $display("FAIL basic_timing got start=%0d stop=%0d fall=%0d done_at=%0d dones=%0d expected 1 6 9 9 1",
               st, sp, fl, dn_at, dn);
    end
  endtask

  task automatic test_min;
    int t0, st = -1, sp = -1, fl = -1, dn = 0;
    delay_i = 8'd0; width_i = 4'd0;
    trig_i = 1'b1; t0 = cyc;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      checks++;
      if (got_vec() !== exp_vec(cyc)) begin
        errors++;
        $display("FAIL min_cycle cyc=%0d got=%b expected=%b", cyc, got_vec(), exp_vec(cyc));
      end
      if (start_o && st < 0) st = cyc - t0;
      if (stop_o && sp < 0) sp = cyc - t0;
      if (st >= 0 && !start_o && fl < 0) fl = cyc - t0;
      if (done_o) dn++;
      trig_i = 1'b0;
    end
    checks++;
    if (st !== 1 || sp !== 2 || fl !== 3 || dn !== 1) begin
      errors++;
      $display("FAIL min_timing got start=%0d stop=%0d fall=%0d dones=%0d expected 1 2 3 1", st, sp, fl, dn);
    end
  endtask

  task automatic test_back_to_back;
    int t0, dn = 0;
    delay_i = 8'd10; width_i = 4'd2;
    trig_i = 1'b1; t0 = cyc;
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      checks++;
      if (got_vec() !== exp_vec(cyc)) begin
        errors++;
        $display("FAIL retrig_cycle cyc=%0d got=%b expected=%b", cyc, got_vec(), exp_vec(cyc));
      end
      if (done_o) dn++;
      trig_i = (cyc - t0 == 3);
    end
    checks++;
    if (dn !== 1) begin
      errors++;
      $display("FAIL retrig_dones got=%0d expected=1", dn);
    end
  endtask

  task automatic test_abort;
    int t0, dn = 0;
    delay_i = 8'd8; width_i = 4'd3;
    trig_i = 1'b1; t0 = cyc;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      checks++;
      if (got_vec() !== exp_vec(cyc)) begin
        errors++;
        $display("FAIL abort_cycle cyc=%0d got=%b expected=%b", cyc, got_vec(), exp_vec(cyc));
      end
      if (cyc - t0 == 5) begin
        checks++;
        if ({start_o, stop_o, busy_o} !== 3'b000) begin
          errors++;
          $display("FAIL abort_outputs got=%b expected=000", {start_o, stop_o, busy_o});
        end
      end
      if (done_o) dn++;
      trig_i = 1'b0;
      ena = (cyc - t0 != 4);
    end
    checks++;
    if (dn !== 0) begin
      errors++;
      $display("FAIL abort_dones got=%0d expected=0", dn);
    end
    delay_i = 8'd2; width_i = 4'd2; dn = 0;
    trig_i = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      checks++;
      if (got_vec() !== exp_vec(cyc)) begin
        errors++;
        $display("FAIL rerun_cycle cyc=%0d got=%b expected=%b", cyc, got_vec(), exp_vec(cyc));
      end
      if (done_o) dn++;
      trig_i = 1'b0;
    end
    checks++;
    if (dn !== 1) begin
      errors++;
      $display("FAIL rerun_dones got=%0d expected=1", dn);
    end
  endtask

  task automatic test_reset_mid;
    int dn = 0;
    delay_i = 8'd3; width_i = 4'd6;
    trig_i = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      trig_i = 1'b0;
    end
    trig_i = 1'b1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (got_vec() !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid_async got=%b expected=%b", got_vec(), 8'h00);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      checks++;
      if (got_vec() !== 8'h00) begin
        errors++;
        $display("FAIL reset_held_trig cyc=%0d got=%b expected=%b", cyc, got_vec(), 8'h00);
      end
    end
    trig_i = 1'b0;
    @(negedge clk);
    trig_i = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      checks++;
      if (got_vec() !== exp_vec(cyc)) begin
        errors++;
        $display("FAIL post_reset_cycle cyc=%0d got=%b expected=%b", cyc, got_vec(), exp_vec(cyc));
      end
      if (done_o) dn++;
      trig_i = 1'b0;
    end
    checks++;
    if (dn !== 1) begin
      errors++;
      $display("FAIL post_reset_dones got=%0d expected=1", dn);
    end
  endtask

  task automatic test_max_delay;
    int t0, sp = -1;
    delay_i = 8'd255; width_i = 4'd1;
    trig_i = 1'b1; t0 = cyc;
    for (int k = 1; k <= 260; k++) begin
      @(negedge clk);
      checks++;
      if (got_vec() !== exp_vec(cyc)) begin
        errors++;
        $display("FAIL maxd_cycle cyc=%0d got=%b expected=%b", cyc, got_vec(), exp_vec(cyc));
      end
      if (stop_o && sp < 0) sp = cyc - t0;
      trig_i = 1'b0;
    end
    checks++;
    if (sp !== 256) begin
      errors++;
      $display("FAIL maxd_stop got=%0d expected=256", sp);
    end
  endtask

`ifdef TDC_STIM_REPEAT_EN
  task automatic test_repeat;
    int t0, ns = 0, np = 0, dn = 0, dn_at = -1;
    int st_at[3], sp_at[3];
    logic [3:0] run_at[3];
    logic prev_s = 1'b0, prev_p = 1'b0;
    delay_i = 8'd4; width_i = 4'd2; rep_i = 4'd2;
    trig_i = 1'b1; t0 = cyc;
    for (int k = 1; k <= 26; k++) begin
      @(negedge clk);
      checks++;
      if (got_vec() !== exp_vec(cyc)) begin
        errors++;
        $display("FAIL repeat_cycle cyc=%0d got=%b expected=%b", cyc, got_vec(), exp_vec(cyc));
      end
      if (start_o && !prev_s && ns < 3) begin st_at[ns] = cyc - t0; run_at[ns] = run_w; ns++; end
      if (stop_o && !prev_p && np < 3) begin sp_at[np] = cyc - t0; np++; end
      if (done_o) begin dn++; dn_at = cyc - t0; end
      prev_s = start_o; prev_p = stop_o;
      trig_i = 1'b0;
    end
    checks++;
    if (ns !== 3 || np !== 3 || st_at[0] !== 1 || st_at[1] !== 9 || st_at[2] !== 17 ||
        sp_at[0] !== 5 || sp_at[1] !== 13 || sp_at[2] !== 21 ||
        run_at[0] !== 4'd0 || run_at[1] !== 4'd1 || run_at[2] !== 4'd2 || dn !== 1 || dn_at !== 23) begin
      errors++;
      $display("FAIL repeat_timing got starts=%0d stops=%0d dones=%0d done_at=%0d expected 3 3 1 23",
               ns, np, dn, dn_at);
    end
    rep_i = 4'd0;
  endtask
`endif

  task automatic test_random;
    for (int k = 0; k < 800; k++) begin
      @(negedge clk);
      checks++;
      if (got_vec() !== exp_vec(cyc)) begin
        errors++;
        $display("FAIL random_cycle cyc=%0d got=%b expected=%b", cyc, got_vec(), exp_vec(cyc));
      end
      trig_i  = ($urandom_range(0, 2) == 0);
      ena     = ($urandom_range(0, 40) != 0);
      delay_i = 8'($urandom_range(0, 12));
      width_i = 4'($urandom_range(0, 15));
      rep_i   = 4'($urandom_range(0, 3));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_min();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    test_max_delay();
`ifdef TDC_STIM_REPEAT_EN
    test_repeat();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tdc_stim_gen.md
TDC_STIM_GEN -- requirements
Module: tdc_stim_gen

Interface
REQ-001 SHALL have parameter DELAY_W, default 8, width of the start-to-stop delay field in clock cycles.
REQ-002 SHALL have parameter WIDTH_W, default 4, width of the pulse-hold field in clock cycles.
REQ-003 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port ena  input  1  block enable; low aborts any run.
REQ-006 SHALL have port trig_i  input  1  run request; a rising edge starts one measurement stimulus.
REQ-007 SHALL have port delay_i  input  DELAY_W  start-to-stop delay request, in cycles.
REQ-008 SHALL have port width_i  input  WIDTH_W  hold time of start/stop after stop rises, in cycles.
REQ-009 SHALL have port start_o  output  1  TDC start edge.
REQ-010 SHALL have port stop_o  output  1  TDC stop edge.
REQ-011 SHALL have port busy_o  output  1  run in progress.
REQ-012 SHALL have port done_o  output  1  one-cycle completion strobe.

Function
REQ-013 SHALL register trig_i and detect a rising edge at cycle T when trig_i=1 at T and trig_i=0 at T-1.
REQ-014 SHALL, in IDLE with ena=1, accept the edge at T and latch D=max(delay_i,1) and W=max(width_i,1) at T.
REQ-015 SHALL use FSM states IDLE -> START -> HOLD -> DONE -> IDLE.
REQ-016 SHALL drive start_o=1 from T+1 until the end of the run, and drive busy_o=1 from T+1 through the done_o cycle.
REQ-017 SHALL drive stop_o=1 from T+1+D, exactly D cycles after start_o rises.
REQ-018 SHALL drop start_o and stop_o together at T+1+D+W.
REQ-019 SHALL pulse done_o for exactly cycle T+1+D+W, then return to IDLE.
REQ-020 SHALL ignore trig_i edges while busy_o=1 and SHALL NOT queue them.
REQ-021 SHALL ignore changes to delay_i and width_i after latching.
REQ-022 SHALL, on ena=0 mid-run, force start_o, stop_o and busy_o low on the next edge and return to IDLE without done_o.
REQ-023 SHALL saturate rather than wrap: the maximum D is 2^DELAY_W-1, counted exactly.

Reset
REQ-024 SHALL, on rst_n low, asynchronously force start_o=0, stop_o=0, busy_o=0, done_o=0, state IDLE, counters 0 and the trig_i history register 0.
REQ-025 SHALL treat reset released while trig_i=1 as no edge; the first run then needs trig_i low and high again.

Configuration
REQ-026 SHALL, with macro TDC_STIM_REPEAT_EN defined, add input rep_i (4 bits) and output run_o (4 bits).
REQ-027 SHALL, with TDC_STIM_REPEAT_EN defined, latch rep_i at T and perform rep_i+1 runs with the same D and W.
REQ-028 SHALL, with TDC_STIM_REPEAT_EN defined, hold start_o and stop_o low for W cycles between runs, keep busy_o high across the whole burst, and pulse done_o only after the final run.
REQ-029 SHALL, with TDC_STIM_REPEAT_EN defined, drive run_o as the index of the current run (0-based), reset to 0.
REQ-030 SHALL, without TDC_STIM_REPEAT_EN, omit the rep_i and run_o ports and perform exactly one run per trigger.

Structure
REQ-031 SHALL place the FSM state enum and the default DELAY_W/WIDTH_W constants in package tdc_stim_pkg.
REQ-032 SHALL implement the loadable, saturating down-counter as sub-module tdc_stim_cnt, instantiated once and reused for the D, W and gap phases.

Verification
REQ-033 SHALL cover: delay_i=5, width_i=3, trig at T -> start_o rises T+1, stop_o rises T+6, both fall T+9, done_o only at T+9.
REQ-034 SHALL cover: delay_i=0, width_i=0 -> stop_o rises 1 cycle after start_o, both fall 1 cycle later, done_o 1 cycle.
REQ-035 SHALL cover: second trig edge at T+3 during a delay_i=10 run -> ignored, exactly one done_o.
REQ-036 SHALL cover: ena dropped at T+4 with delay_i=8 -> outputs low at T+5, no done_o, next trig edge starts a clean run.
REQ-037 SHALL cover: rst_n pulsed low mid-HOLD -> all outputs 0 immediately; trig_i held high through release produces no run.
REQ-038 SHALL cover, with TDC_STIM_REPEAT_EN: rep_i=2, delay_i=4, width_i=2 -> three start/stop pairs spaced by 2-cycle gaps, run_o stepping 0,1,2, a single done_o at the end.
